// File: rtl/data_mem_unit.sv
// data_mem_unit
//   Byte-addressed data memory for the MEM stage. Supports RV32I load/store
//   sizes with sign/zero extension, a configurable read latency and a
//   valid/ready request channel with a one-cycle response strobe. Misaligned,
//   out-of-range and illegal-size accesses are reported through resp_err and
//   never modify memory.
//
// Ports
//   clk         rising-edge clock
//   reset_n     synchronous active-low reset
//   req_valid   request present
//   req_ready   unit can accept a request this cycle
//   req_write   1 = store, 0 = load
//   req_addr    byte address
//   req_funct3  RV32I funct3 of the access
//   req_wdata   store data (low bytes used for sb/sh)
//   resp_valid  one-cycle response strobe
//   resp_rdata  extended load data; 0 for stores and errors
//   resp_err    access faulted; qualified by resp_valid
//   busy        a read is outstanding (= ~req_ready)
module data_mem_unit #(
  parameter int unsigned DEPTH_BYTES   = 128,
  parameter int unsigned ADDR_W        = 32,
  parameter int unsigned RD_LATENCY    = 1,
  parameter bit          LITTLE_ENDIAN = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              busy
);

  localparam int unsigned AW  = $clog2(DEPTH_BYTES);
  localparam int unsigned AWX = ADDR_W + 1;
  // Pipeline stages ahead of the response register; at least one so the
  // arrays stay legal when RD_LATENCY == 1 (they are then unused).
  localparam int unsigned PD  = (RD_LATENCY > 1) ? RD_LATENCY - 1 : 1;
  localparam int unsigned CW  = 3;

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;

  logic [7:0]      r_mem [DEPTH_BYTES];

  logic [PD-1:0]   r_pv;
  logic [31:0]     r_pd [PD];
  logic [PD-1:0]   r_pe;

  logic            r_resp_valid;
  logic [31:0]     r_resp_rdata;
  logic            r_resp_err;

  logic            w_accept;
  logic            w_ld_acc;
  logic            w_st_acc;
  logic [1:0]      w_sz;
  logic            w_f3_ok;
  logic            w_align_ok;
  logic            w_range_ok;
  logic            w_err;
  logic [1:0]      w_size_m1;
  logic [AWX-1:0]  w_last;
  logic [AW-1:0]   w_idx;
  logic [AW-1:0]   w_ba [4];
  logic [7:0]      w_rb [4];
  logic [7:0]      w_wb [4];
  logic [3:0]      w_we;
  logic [31:0]     w_ldata;

  assign req_ready = (r_state == S_IDLE);
  assign busy      = ~req_ready;

  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;

  assign w_accept = req_valid & req_ready;
  assign w_ld_acc = w_accept & ~req_write;
  assign w_st_acc = w_accept & req_write;
  assign w_sz     = req_funct3[1:0];
  assign w_idx    = req_addr[AW-1:0];

  // Access decode and fault detection
  always_comb begin
    w_f3_ok    = 1'b0;
    w_align_ok = 1'b1;
    w_size_m1  = 2'd0;

    if (req_write) begin
      w_f3_ok = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                (req_funct3 == 3'b010);
    end else begin
      w_f3_ok = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                (req_funct3 == 3'b010) || (req_funct3 == 3'b100) ||
                (req_funct3 == 3'b101);
    end

    case (w_sz)
      2'b01: begin
        w_align_ok = ~req_addr[0];
        w_size_m1  = 2'd1;
      end
      2'b10: begin
        w_align_ok = (req_addr[1:0] == 2'b00);
        w_size_m1  = 2'd3;
      end
      default: begin
        w_align_ok = 1'b1;
        w_size_m1  = 2'd0;
      end
    endcase
  end

  // Extended to ADDR_W+1 bits so an access near the top of the address
  // space cannot wrap back into range.
  assign w_last     = {1'b0, req_addr} + AWX'(w_size_m1);
  assign w_range_ok = (w_last < AWX'(DEPTH_BYTES));
  assign w_err      = ~(w_f3_ok & w_align_ok & w_range_ok);

  // Byte lanes: lane k is the byte at address idx+k
  always_comb begin
    for (int unsigned k = 0; k < 4; k++) begin
      w_ba[k] = w_idx + AW'(k);
      w_rb[k] = r_mem[w_ba[k]];
    end
  end

  // Load data extraction and extension
  always_comb begin
    w_ldata = '0;
    case (w_sz)
      2'b00: begin
        w_ldata = {{24{~req_funct3[2] & w_rb[0][7]}}, w_rb[0]};
      end
      2'b01: begin
        if (LITTLE_ENDIAN) begin
          w_ldata = {{16{~req_funct3[2] & w_rb[1][7]}}, w_rb[1], w_rb[0]};
        end else begin
          w_ldata = {{16{~req_funct3[2] & w_rb[0][7]}}, w_rb[0], w_rb[1]};
        end
      end
      2'b10: begin
        if (LITTLE_ENDIAN) begin
          w_ldata = {w_rb[3], w_rb[2], w_rb[1], w_rb[0]};
        end else begin
          w_ldata = {w_rb[0], w_rb[1], w_rb[2], w_rb[3]};
        end
      end
      default: w_ldata = '0;
    endcase
    if (w_err) begin
      w_ldata = '0;
    end
  end

  // Store byte enables and lane data
  always_comb begin
    w_we = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      w_wb[k] = '0;
    end
    case (w_sz)
      2'b00: begin
        w_we    = 4'b0001;
        w_wb[0] = req_wdata[7:0];
      end
      2'b01: begin
        w_we = 4'b0011;
        if (LITTLE_ENDIAN) begin
          w_wb[0] = req_wdata[7:0];
          w_wb[1] = req_wdata[15:8];
        end else begin
          w_wb[0] = req_wdata[15:8];
          w_wb[1] = req_wdata[7:0];
        end
      end
      2'b10: begin
        w_we = 4'b1111;
        for (int unsigned k = 0; k < 4; k++) begin
          if (LITTLE_ENDIAN) begin
            w_wb[k] = req_wdata[8*k +: 8];
          end else begin
            w_wb[k] = req_wdata[8*(3-k) +: 8];
          end
        end
      end
      default: w_we = '0;
    endcase
    if (!w_st_acc || w_err) begin
      w_we = '0;
    end
  end

  // Memory array
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH_BYTES; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (w_we[k]) begin
          r_mem[w_ba[k]] <= w_wb[k];
        end
      end
    end
  end

  // Read pipeline, response register and load FSM.
  // Stores bypass the pipeline and respond the next cycle; they cannot
  // collide with a load response because req_ready is low until the cycle
  // in which that response is already in the output register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_pv         <= '0;
      r_pe         <= '0;
      for (int unsigned i = 0; i < PD; i++) begin
        r_pd[i] <= '0;
      end
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      r_pv[0] <= w_ld_acc;
      r_pd[0] <= w_ldata;
      r_pe[0] <= w_ld_acc & w_err;
      for (int unsigned i = 1; i < PD; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pd[i] <= r_pd[i-1];
        r_pe[i] <= r_pe[i-1];
      end

      if (w_st_acc) begin
        r_resp_valid <= 1'b1;
        r_resp_rdata <= '0;
        r_resp_err   <= w_err;
      end else if (RD_LATENCY == 1) begin
        r_resp_valid <= w_ld_acc;
        r_resp_rdata <= w_ld_acc ? w_ldata : '0;
        r_resp_err   <= w_ld_acc & w_err;
      end else begin
        r_resp_valid <= r_pv[PD-1];
        r_resp_rdata <= r_pv[PD-1] ? r_pd[PD-1] : '0;
        r_resp_err   <= r_pv[PD-1] & r_pe[PD-1];
      end

      case (r_state)
        S_IDLE: begin
          if (w_ld_acc && (RD_LATENCY > 1)) begin
            r_state <= S_WAIT;
            r_cnt   <= CW'(RD_LATENCY - 1);
          end
        end
        S_WAIT: begin
          if (r_cnt == CW'(1)) begin
            r_state <= S_IDLE;
          end
          r_cnt <= r_cnt - CW'(1);
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_unit.sv
// tb_data_mem_unit
//   Directed bench for data_mem_unit. Three instances share the clock, reset
//   and request fields; r_sel picks which one receives req_valid and whose
//   outputs are observed:
//     0: RD_LATENCY=1, little-endian
//     1: RD_LATENCY=3, little-endian
//     2: RD_LATENCY=4, big-endian
module tb_data_mem_unit;

  logic        clk;
  logic        r_rst_n;
  logic        r_valid;
  logic        r_write;
  logic [31:0] r_addr;
  logic [2:0]  r_f3;
  logic [31:0] r_wdata;
  int          r_sel;

  logic        w_rdy0, w_rv0, w_re0, w_bz0;
  logic        w_rdy1, w_rv1, w_re1, w_bz1;
  logic        w_rdy2, w_rv2, w_re2, w_bz2;
  logic [31:0] w_rd0, w_rd1, w_rd2;

  logic        w_ready, w_rv, w_re, w_busy;
  logic [31:0] w_rd;

  int n_checks;
  int n_errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  data_mem_unit #(.DEPTH_BYTES(128), .ADDR_W(32), .RD_LATENCY(1), .LITTLE_ENDIAN(1'b1)) u_l1 (
    .clk(clk), .reset_n(r_rst_n), .req_valid(r_valid && (r_sel == 0)), .req_ready(w_rdy0),
    .req_write(r_write), .req_addr(r_addr), .req_funct3(r_f3), .req_wdata(r_wdata),
    .resp_valid(w_rv0), .resp_rdata(w_rd0), .resp_err(w_re0), .busy(w_bz0));

  data_mem_unit #(.DEPTH_BYTES(128), .ADDR_W(32), .RD_LATENCY(3), .LITTLE_ENDIAN(1'b1)) u_l3 (
    .clk(clk), .reset_n(r_rst_n), .req_valid(r_valid && (r_sel == 1)), .req_ready(w_rdy1),
    .req_write(r_write), .req_addr(r_addr), .req_funct3(r_f3), .req_wdata(r_wdata),
    .resp_valid(w_rv1), .resp_rdata(w_rd1), .resp_err(w_re1), .busy(w_bz1));

  data_mem_unit #(.DEPTH_BYTES(128), .ADDR_W(32), .RD_LATENCY(4), .LITTLE_ENDIAN(1'b0)) u_l4 (
    .clk(clk), .reset_n(r_rst_n), .req_valid(r_valid && (r_sel == 2)), .req_ready(w_rdy2),
    .req_write(r_write), .req_addr(r_addr), .req_funct3(r_f3), .req_wdata(r_wdata),
    .resp_valid(w_rv2), .resp_rdata(w_rd2), .resp_err(w_re2), .busy(w_bz2));

  assign w_ready = (r_sel == 0) ? w_rdy0 : (r_sel == 1) ? w_rdy1 : w_rdy2;
  assign w_rv    = (r_sel == 0) ? w_rv0  : (r_sel == 1) ? w_rv1  : w_rv2;
  assign w_rd    = (r_sel == 0) ? w_rd0  : (r_sel == 1) ? w_rd1  : w_rd2;
  assign w_re    = (r_sel == 0) ? w_re0  : (r_sel == 1) ? w_re1  : w_re2;
  assign w_busy  = (r_sel == 0) ? w_bz0  : (r_sel == 1) ? w_bz1  : w_bz2;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // One isolated transaction: present it, wait for the response within a
  // bounded window, then check latency, data, error and ready recovery.
  task automatic xact(input string tag, input logic wr, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] ed, input logic ee, input int lat);
    int n;
    @(negedge clk);
    chk({tag, "_rdy"}, w_ready, 1);
    r_valid = 1'b1;
    r_write = wr;
    r_f3    = f3;
    r_addr  = a;
    r_wdata = wd;
    @(posedge clk);
    #1 r_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!w_rv && n < lat) chk({tag, "_stall"}, w_ready, 0);
    end while (!w_rv && n < 10);
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_data"}, w_rd, ed);
    chk({tag, "_err"}, w_re, ee);
    chk({tag, "_rdyback"}, w_ready, 1);
  endtask

  initial begin
    int seen;
    n_checks = 0;
    n_errors = 0;
    r_sel    = 0;
    r_rst_n  = 1'b0;
    r_valid  = 1'b0;
    r_write  = 1'b0;
    r_addr   = '0;
    r_f3     = '0;
    r_wdata  = '0;
    repeat (3) @(posedge clk);
    #1 r_rst_n = 1'b1;

    @(negedge clk);
    chk("rst_ready", w_ready, 1);
    chk("rst_busy",  w_busy, 0);
    chk("rst_rv",    w_rv, 0);
    chk("rst_rdata", w_rd, 0);
    chk("rst_err",   w_re, 0);

    // ---- RD_LATENCY=1, little-endian ----
    r_sel = 0;
    xact("sw20",  1, 3'b010, 20, 32'h8000_00FF, 32'h0, 0, 1);
    xact("lw20",  0, 3'b010, 20, 0, 32'h8000_00FF, 0, 1);
    xact("lb20",  0, 3'b000, 20, 0, 32'hFFFF_FFFF, 0, 1);
    xact("lbu20", 0, 3'b100, 20, 0, 32'h0000_00FF, 0, 1);
    xact("lh22",  0, 3'b001, 22, 0, 32'hFFFF_8000, 0, 1);
    xact("lhu22", 0, 3'b101, 22, 0, 32'h0000_8000, 0, 1);

    xact("sw0_20", 1, 3'b010, 20, 32'h0, 0, 0, 1);
    xact("sb21",   1, 3'b000, 21, 32'hFFFF_FF6D, 0, 0, 1);
    xact("lw20b",  0, 3'b010, 20, 0, 32'h0000_6D00, 0, 1);
    xact("lh20",   0, 3'b001, 20, 0, 32'h0000_6D00, 0, 1);
    xact("lb21",   0, 3'b000, 21, 0, 32'h0000_006D, 0, 1);

    xact("sw4",   1, 3'b010, 4,   32'h1111_1111, 0, 0, 1);
    xact("sw0",   1, 3'b010, 0,   32'h2222_2222, 0, 0, 1);
    xact("sw124", 1, 3'b010, 124, 32'h3333_3333, 0, 0, 1);
    xact("e_lw6",    0, 3'b010, 6,   0, 0, 1, 1);
    xact("e_sh3",    1, 3'b001, 3,   32'h0000_FFFF, 0, 1, 1);
    xact("e_ld011",  0, 3'b011, 4,   0, 0, 1, 1);
    xact("e_lw126",  0, 3'b010, 126, 0, 0, 1, 1);
    xact("e_st011",  1, 3'b011, 0,   32'hFFFF_FFFF, 0, 1, 1);
    xact("e_lbu128", 0, 3'b100, 128, 0, 0, 1, 1);
    xact("e_lwhigh", 0, 3'b010, 32'h1000_0000, 0, 0, 1, 1);
    xact("e_lh127",  0, 3'b001, 127, 0, 0, 1, 1);
    xact("e_sw2",    1, 3'b010, 2,   32'hDEAD_BEEF, 0, 1, 1);
    xact("v_lw4",    0, 3'b010, 4,   0, 32'h1111_1111, 0, 1);
    xact("v_lw0",    0, 3'b010, 0,   0, 32'h2222_2222, 0, 1);
    xact("v_lw124",  0, 3'b010, 124, 0, 32'h3333_3333, 0, 1);
    xact("sb127",    1, 3'b000, 127, 32'h0000_005A, 0, 0, 1);
    xact("lw124b",   0, 3'b010, 124, 0, 32'h5A33_3333, 0, 1);
    xact("lbu127",   0, 3'b100, 127, 0, 32'h0000_005A, 0, 1);

    // Store immediately followed by a load of the same word
    @(negedge clk);
    r_valid = 1'b1; r_write = 1'b1; r_f3 = 3'b010; r_addr = 40; r_wdata = 32'hCAFE_F00D;
    @(posedge clk);
    #1 r_write = 1'b0; r_wdata = '0;
    @(negedge clk);
    chk("raw_st_rv",  w_rv, 1);
    chk("raw_st_rd",  w_rd, 0);
    chk("raw_ready",  w_ready, 1);
    @(posedge clk);
    #1 r_valid = 1'b0;
    @(negedge clk);
    chk("raw_ld_rv", w_rv, 1);
    chk("raw_ld_rd", w_rd, 32'hCAFE_F00D);

    // ---- RD_LATENCY=3 ----
    r_sel = 1;
    xact("l3_sw0",  1, 3'b010, 0, 32'hA5A5_0001, 0, 0, 1);
    xact("l3_sw4",  1, 3'b010, 4, 32'h0000_BEEF, 0, 0, 1);
    xact("l3_lhu4", 0, 3'b101, 4, 0, 32'h0000_BEEF, 0, 3);
    xact("l3_elw2", 0, 3'b010, 2, 0, 0, 1, 3);

    // Second load held valid while the first is outstanding
    @(negedge clk);                           // cycle c
    r_valid = 1'b1; r_write = 1'b0; r_f3 = 3'b010; r_addr = 0;
    @(posedge clk);
    #1 r_addr = 4;                            // held request
    @(negedge clk);                           // c+1
    chk("l3_c1_rdy", w_ready, 0);
    chk("l3_c1_bsy", w_busy, 1);
    chk("l3_c1_rv",  w_rv, 0);
    @(negedge clk);                           // c+2
    chk("l3_c2_rdy", w_ready, 0);
    chk("l3_c2_rv",  w_rv, 0);
    @(negedge clk);                           // c+3
    chk("l3_c3_rv",  w_rv, 1);
    chk("l3_c3_rd",  w_rd, 32'hA5A5_0001);
    chk("l3_c3_rdy", w_ready, 1);
    @(posedge clk);                           // second accepted
    #1 r_valid = 1'b0;
    @(negedge clk);                           // c+4
    chk("l3_c4_rv",  w_rv, 0);
    chk("l3_c4_rdy", w_ready, 0);
    @(negedge clk);                           // c+5
    chk("l3_c5_rv",  w_rv, 0);
    @(negedge clk);                           // c+6
    chk("l3_c6_rv",  w_rv, 1);
    chk("l3_c6_rd",  w_rd, 32'h0000_BEEF);
    @(negedge clk);                           // c+7
    chk("l3_c7_rv",  w_rv, 0);

    // ---- RD_LATENCY=4, big-endian ----
    r_sel = 2;
    xact("be_sw8",   1, 3'b010, 8,  32'h1122_3344, 0, 0, 1);
    xact("be_lbu8",  0, 3'b100, 8,  0, 32'h0000_0011, 0, 4);
    xact("be_lhu10", 0, 3'b101, 10, 0, 32'h0000_3344, 0, 4);
    xact("be_lh8",   0, 3'b001, 8,  0, 32'h0000_1122, 0, 4);
    xact("be_lw8",   0, 3'b010, 8,  0, 32'h1122_3344, 0, 4);

    // Reset during an outstanding read drops it
    @(negedge clk);
    r_valid = 1'b1; r_write = 1'b0; r_f3 = 3'b010; r_addr = 8;
    @(posedge clk);                           // accepted, cycle c
    #1 r_valid = 1'b0;
    @(negedge clk);                           // c+1
    chk("rs_c1_rv", w_rv, 0);
    @(posedge clk);
    #1 r_rst_n = 1'b0;                        // c+2
    @(posedge clk);
    #1 r_rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (w_rv) seen++;
    end
    chk("rs_norsp",  seen, 0);
    chk("rs_ready",  w_ready, 1);
    chk("rs_busy",   w_busy, 0);
    xact("rs_lw8", 0, 3'b010, 8, 0, 32'h0, 0, 4);
    xact("rs_lw0", 0, 3'b010, 0, 0, 32'h0, 0, 4);
    r_sel = 0;
    xact("rs_l1_lw20", 0, 3'b010, 20, 0, 32'h0, 0, 1);
    xact("rs_l1_lw40", 0, 3'b010, 40, 0, 32'h0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
